id_ex_stage: RTL and testbench

Pipeline register between decode and the ALU. It captures decoded operands and control under a valid/ready handshake, and drives `operand_a`, `operand_b` and `alu_ctrl` into the ALU with EX/MEM and MEM/WB forwarding applied. It also produces a clock-enable for the stage's integrated clock gate, so the stage registers toggle only when their contents must change.

---
 rtl/id_ex_if.sv | 52 +++++
 rtl/id_ex_stage.sv | 124 ++++++++++++
 tb/tb_id_ex_stage.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// Bundle of decode-side, forwarding and ALU-side signals around the ID/EX register.
// valid/ready: a transfer happens on a rising edge where valid and ready are both high; the sender holds its payload steady while valid is high and ready low.
interface id_ex_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
);
   logic                      in_valid;
   logic                      in_ready;
   logic [DATA_WIDTH-1:0]     in_rs1_data;
   logic [DATA_WIDTH-1:0]     in_rs2_data;
   logic [DATA_WIDTH-1:0]     in_imm;
   logic [REG_ADDR_WIDTH-1:0] in_rs1_addr;
   logic [REG_ADDR_WIDTH-1:0] in_rs2_addr;
   logic [REG_ADDR_WIDTH-1:0] in_rd_addr;
   logic                      in_use_imm;
   logic [3:0]                in_alu_ctrl;
   logic                      in_reg_write;
   logic                      flush;
   logic                      exmem_reg_write;
   logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr;
   logic [DATA_WIDTH-1:0]     exmem_result;
   logic                      memwb_reg_write;
   logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr;
   logic [DATA_WIDTH-1:0]     memwb_result;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_WIDTH-1:0]     operand_a;
   logic [DATA_WIDTH-1:0]     operand_b;
   logic [3:0]                alu_ctrl;
   logic [REG_ADDR_WIDTH-1:0] rd_addr;
   logic                      reg_write;
   logic                      stage_clk_en;
   logic [15:0]               stall_cycles;

   modport master (
      output in_valid, in_rs1_data, in_rs2_data, in_imm, in_rs1_addr, in_rs2_addr,
             in_rd_addr, in_use_imm, in_alu_ctrl, in_reg_write, flush,
             exmem_reg_write, exmem_rd_addr, exmem_result,
             memwb_reg_write, memwb_rd_addr, memwb_result, out_ready,
      input  in_ready, out_valid, operand_a, operand_b, alu_ctrl, rd_addr,
             reg_write, stage_clk_en, stall_cycles
   );

   modport slave (
      input  in_valid, in_rs1_data, in_rs2_data, in_imm, in_rs1_addr, in_rs2_addr,
             in_rd_addr, in_use_imm, in_alu_ctrl, in_reg_write, flush,
             exmem_reg_write, exmem_rd_addr, exmem_result,
             memwb_reg_write, memwb_rd_addr, memwb_result, out_ready,
      output in_ready, out_valid, operand_a, operand_b, alu_ctrl, rd_addr,
             reg_write, stage_clk_en, stall_cycles
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and a clock-gate enable.
// The stall counter is clocked ungated; every other register only moves when stage_clk_en is high.
module id_ex_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input logic   clk,
   input logic   rst_n,
   id_ex_if.slave bus
);
   logic                      valid_q, valid_d;
   logic [DATA_WIDTH-1:0]     rs1_data_q, rs1_data_d;
   logic [DATA_WIDTH-1:0]     rs2_data_q, rs2_data_d;
   logic [DATA_WIDTH-1:0]     imm_q, imm_d;
   logic [REG_ADDR_WIDTH-1:0] rs1_addr_q, rs1_addr_d;
   logic [REG_ADDR_WIDTH-1:0] rs2_addr_q, rs2_addr_d;
   logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                      use_imm_q, use_imm_d;
   logic [3:0]                alu_ctrl_q, alu_ctrl_d;
   logic                      reg_write_q, reg_write_d;
   logic [15:0]               stall_q;

   logic                      in_ready, accept, hold, consume;
   logic                      ex_hit_a, mem_hit_a, ex_hit_b, mem_hit_b;
   logic                      hit_a, hit_b, fwd_hit, clk_en;
   logic [DATA_WIDTH-1:0]     fwd_a, fwd_b;

   assign in_ready = ~valid_q | bus.out_ready;
   assign accept   = bus.in_valid & in_ready;
   assign hold     = valid_q & ~bus.out_ready;
   assign consume  = valid_q & bus.out_ready;

   // x0 is hard-wired zero, so a producer targeting it never forwards.
   always_comb begin
      ex_hit_a  = bus.exmem_reg_write && (bus.exmem_rd_addr != '0) && (bus.exmem_rd_addr == rs1_addr_q);
      mem_hit_a = bus.memwb_reg_write && (bus.memwb_rd_addr != '0) && (bus.memwb_rd_addr == rs1_addr_q);
      ex_hit_b  = bus.exmem_reg_write && (bus.exmem_rd_addr != '0) && (bus.exmem_rd_addr == rs2_addr_q);
      mem_hit_b = bus.memwb_reg_write && (bus.memwb_rd_addr != '0) && (bus.memwb_rd_addr == rs2_addr_q);
      fwd_a     = ex_hit_a ? bus.exmem_result : (mem_hit_a ? bus.memwb_result : rs1_data_q);
      fwd_b     = ex_hit_b ? bus.exmem_result : (mem_hit_b ? bus.memwb_result : rs2_data_q);
      hit_a     = ex_hit_a | mem_hit_a;
      hit_b     = (ex_hit_b | mem_hit_b) & ~use_imm_q;
      fwd_hit   = hit_a | hit_b;
   end

   assign clk_en = bus.flush | accept | consume | (hold & fwd_hit);

   always_comb begin
      valid_d     = valid_q;
      rs1_data_d  = rs1_data_q;
      rs2_data_d  = rs2_data_q;
      imm_d       = imm_q;
      rs1_addr_d  = rs1_addr_q;
      rs2_addr_d  = rs2_addr_q;
      rd_addr_d   = rd_addr_q;
      use_imm_d   = use_imm_q;
      alu_ctrl_d  = alu_ctrl_q;
      reg_write_d = reg_write_q;
      if (bus.flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d     = 1'b1;
         rs1_data_d  = bus.in_rs1_data;
         rs2_data_d  = bus.in_rs2_data;
         imm_d       = bus.in_imm;
         rs1_addr_d  = bus.in_rs1_addr;
         rs2_addr_d  = bus.in_rs2_addr;
         rd_addr_d   = bus.in_rd_addr;
         use_imm_d   = bus.in_use_imm;
         alu_ctrl_d  = bus.in_alu_ctrl;
         reg_write_d = bus.in_reg_write;
      end else if (consume) begin
         valid_d = 1'b0;
      end else if (hold) begin
         // Capture forwarded values so they survive the producer leaving the pipe.
         if (hit_a) rs1_data_d = fwd_a;
         if (hit_b) rs2_data_d = fwd_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         rs1_addr_q  <= '0;
         rs2_addr_q  <= '0;
         rd_addr_q   <= '0;
         use_imm_q   <= 1'b0;
         alu_ctrl_q  <= 4'b0000;
         reg_write_q <= 1'b0;
      end else if (clk_en) begin
         valid_q     <= valid_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         imm_q       <= imm_d;
         rs1_addr_q  <= rs1_addr_d;
         rs2_addr_q  <= rs2_addr_d;
         rd_addr_q   <= rd_addr_d;
         use_imm_q   <= use_imm_d;
         alu_ctrl_q  <= alu_ctrl_d;
         reg_write_q <= reg_write_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= 16'h0000;
      end else if (hold && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = valid_q;
   assign bus.operand_a    = fwd_a;
   assign bus.operand_b    = use_imm_q ? imm_q : fwd_b;
   assign bus.alu_ctrl     = alu_ctrl_q;
   assign bus.rd_addr      = rd_addr_q;
   assign bus.reg_write    = reg_write_q & valid_q;
   assign bus.stage_clk_en = clk_en;
   assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus a scoreboard of expected ALU-side beats.
module tb_id_ex_stage;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int PW = 4 + AW + 1 + 2 * DW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   id_ex_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();
   id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [PW-1:0] exp_q[$];
   logic [PW-1:0] mon_got, mon_exp;
   int n_checks = 0;
   int n_pass   = 0;

   function automatic logic [PW-1:0] pk(input logic [3:0] op, input logic [AW-1:0] rd,
                                        input logic rw, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
      return {op, rd, rw, a, b};
   endfunction

   task automatic set_idle();
      bus.in_valid = 0; bus.in_rs1_data = 0; bus.in_rs2_data = 0; bus.in_imm = 0;
      bus.in_rs1_addr = 0; bus.in_rs2_addr = 0; bus.in_rd_addr = 0; bus.in_use_imm = 0;
      bus.in_alu_ctrl = 0; bus.in_reg_write = 0; bus.flush = 0;
      bus.exmem_reg_write = 0; bus.exmem_rd_addr = 0; bus.exmem_result = 0;
      bus.memwb_reg_write = 0; bus.memwb_rd_addr = 0; bus.memwb_result = 0;
      bus.out_ready = 0;
   endtask

   task automatic drive_instr(input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                              input logic [DW-1:0] imm, input logic [AW-1:0] a1,
                              input logic [AW-1:0] a2, input logic [AW-1:0] rd,
                              input logic ui, input logic [3:0] op, input logic rw);
      bus.in_valid = 1; bus.in_rs1_data = r1; bus.in_rs2_data = r2; bus.in_imm = imm;
      bus.in_rs1_addr = a1; bus.in_rs2_addr = a2; bus.in_rd_addr = rd;
      bus.in_use_imm = ui; bus.in_alu_ctrl = op; bus.in_reg_write = rw;
   endtask

   // Scoreboard: every consumed beat must match the oldest outstanding expectation.
   always @(negedge clk) begin
      #2;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         mon_got = pk(bus.alu_ctrl, bus.rd_addr, bus.reg_write, bus.operand_a, bus.operand_b);
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_underflow: got %h, no beat expected", mon_got);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) $display("FAIL sb_beat: got %h exp %h", mon_got, mon_exp);
            else n_pass++;
         end
      end
   end

   task automatic test_reset();
      set_idle();
      rst_n = 0;
      @(negedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b exp 0", bus.out_valid); else n_pass++;
      n_checks++; if (bus.alu_ctrl !== 4'b0000) $display("FAIL rst_alu_ctrl: got %b exp 0000", bus.alu_ctrl); else n_pass++;
      n_checks++; if (bus.reg_write !== 1'b0) $display("FAIL rst_reg_write: got %b exp 0", bus.reg_write); else n_pass++;
      n_checks++; if (bus.stall_cycles !== 16'h0) $display("FAIL rst_stall: got %h exp 0000", bus.stall_cycles); else n_pass++;
      n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b exp 1", bus.in_ready); else n_pass++;
      rst_n = 1;
   endtask

   task automatic test_single();
      int en_cnt;
      en_cnt = 0;
      @(negedge clk);
      drive_instr(5, 7, 0, 1, 2, 3, 0, 4'b0000, 1); bus.out_ready = 1; #1;
      if (bus.stage_clk_en === 1'b1) en_cnt++;
      n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL single_in_ready: got %b exp 1", bus.in_ready); else n_pass++;
      exp_q.push_back(pk(4'b0000, 3, 1, 5, 7));
      @(negedge clk); bus.in_valid = 0; #1;
      if (bus.stage_clk_en === 1'b1) en_cnt++;
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL single_valid: got %b exp 1", bus.out_valid); else n_pass++;
      n_checks++; if (bus.operand_a !== 32'd5) $display("FAIL single_op_a: got %h exp 5", bus.operand_a); else n_pass++;
      n_checks++; if (bus.operand_b !== 32'd7) $display("FAIL single_op_b: got %h exp 7", bus.operand_b); else n_pass++;
      @(negedge clk); #1;
      if (bus.stage_clk_en === 1'b1) en_cnt++;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_drain: got %b exp 0", bus.out_valid); else n_pass++;
      @(negedge clk); #1;
      if (bus.stage_clk_en === 1'b1) en_cnt++;
      n_checks++; if (en_cnt != 2) $display("FAIL single_clk_en_pulses: got %0d exp 2", en_cnt); else n_pass++;
   endtask

   task automatic test_forward();
      @(negedge clk);
      drive_instr(32'h11, 32'h22, 0, 3, 4, 8, 0, 4'b0010, 1); bus.out_ready = 1; #1;
      exp_q.push_back(pk(4'b0010, 8, 1, 32'h11, 32'h22));
      @(negedge clk);
      bus.in_valid = 0; bus.out_ready = 0;
      bus.exmem_reg_write = 1; bus.exmem_rd_addr = 3; bus.exmem_result = 32'hAAAA;
      bus.memwb_reg_write = 1; bus.memwb_rd_addr = 3; bus.memwb_result = 32'h5555;
      #1;
      n_checks++; if (bus.operand_a !== 32'hAAAA) $display("FAIL fwd_exmem_prio: got %h exp AAAA", bus.operand_a); else n_pass++;
      bus.exmem_rd_addr = 0; #1;
      n_checks++; if (bus.operand_a !== 32'h5555) $display("FAIL fwd_memwb: got %h exp 5555", bus.operand_a); else n_pass++;
      bus.exmem_reg_write = 0; bus.memwb_reg_write = 0; #1;
      n_checks++; if (bus.operand_a !== 32'h11) $display("FAIL fwd_none: got %h exp 11", bus.operand_a); else n_pass++;
      @(negedge clk);
      drive_instr(32'h77, 32'h66, 0, 0, 0, 9, 0, 4'b0001, 1); bus.out_ready = 1;
      bus.exmem_reg_write = 1; bus.exmem_rd_addr = 0; bus.exmem_result = 32'hAAAA;
      bus.memwb_reg_write = 1; bus.memwb_rd_addr = 0; bus.memwb_result = 32'h5555;
      #1;
      exp_q.push_back(pk(4'b0001, 9, 1, 32'h77, 32'h66));
      @(negedge clk); bus.in_valid = 0; #1;
      n_checks++; if (bus.operand_a !== 32'h77) $display("FAIL fwd_x0: got %h exp 77", bus.operand_a); else n_pass++;
      @(negedge clk);
      bus.exmem_reg_write = 0; bus.memwb_reg_write = 0;
   endtask

   task automatic test_hold_refresh();
      @(negedge clk); rst_n = 0; #1; rst_n = 1;
      @(negedge clk);
      drive_instr(32'h1, 32'h99, 0, 7, 6, 5, 0, 4'b0011, 1); bus.out_ready = 1; #1;
      exp_q.push_back(pk(4'b0011, 5, 1, 32'h1, 32'h1234));
      @(negedge clk);
      bus.in_valid = 0; bus.out_ready = 0;
      bus.memwb_reg_write = 1; bus.memwb_rd_addr = 6; bus.memwb_result = 32'h1234; #1;
      n_checks++; if (bus.stage_clk_en !== 1'b1) $display("FAIL refresh_en_c1: got %b exp 1", bus.stage_clk_en); else n_pass++;
      n_checks++; if (bus.operand_b !== 32'h1234) $display("FAIL refresh_b_c1: got %h exp 1234", bus.operand_b); else n_pass++;
      for (int c = 2; c <= 3; c++) begin
         @(negedge clk); bus.memwb_reg_write = 0; #1;
         n_checks++; if (bus.stage_clk_en !== 1'b0) $display("FAIL refresh_en_c%0d: got %b exp 0", c, bus.stage_clk_en); else n_pass++;
         n_checks++; if (bus.operand_b !== 32'h1234) $display("FAIL refresh_b_c%0d: got %h exp 1234", c, bus.operand_b); else n_pass++;
      end
      @(negedge clk); bus.out_ready = 1; #1;
      n_checks++; if (bus.stall_cycles !== 16'd3) $display("FAIL refresh_stall: got %0d exp 3", bus.stall_cycles); else n_pass++;
   endtask

   task automatic test_imm();
      @(negedge clk);
      drive_instr(32'h31, 32'h55, 32'hFFFFFFFC, 10, 9, 4, 1, 4'b0110, 1); bus.out_ready = 1; #1;
      exp_q.push_back(pk(4'b0110, 4, 1, 32'h31, 32'hFFFFFFFC));
      @(negedge clk);
      bus.in_valid = 0; bus.out_ready = 0;
      bus.exmem_reg_write = 1; bus.exmem_rd_addr = 9; bus.exmem_result = 32'hDEAD; #1;
      n_checks++; if (bus.operand_b !== 32'hFFFFFFFC) $display("FAIL imm_op_b: got %h exp FFFFFFFC", bus.operand_b); else n_pass++;
      n_checks++; if (bus.stage_clk_en !== 1'b0) $display("FAIL imm_no_refresh: got %b exp 0", bus.stage_clk_en); else n_pass++;
      @(negedge clk); bus.exmem_reg_write = 0; bus.out_ready = 1;
      @(negedge clk);
   endtask

   task automatic test_flush();
      @(negedge clk);
      drive_instr(32'h10, 32'h20, 0, 1, 2, 11, 0, 4'b0000, 1); bus.out_ready = 1; #1;
      exp_q.push_back(pk(4'b0000, 11, 1, 32'h10, 32'h20));
      @(negedge clk);
      drive_instr(32'hBAD, 32'hBAD, 0, 1, 2, 12, 0, 4'b0101, 1); bus.flush = 1; #1;
      n_checks++; if (bus.stage_clk_en !== 1'b1) $display("FAIL flush_en: got %b exp 1", bus.stage_clk_en); else n_pass++;
      @(negedge clk);
      bus.flush = 0;
      drive_instr(32'h40, 32'h50, 0, 1, 2, 13, 0, 4'b0100, 1); #1;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_valid: got %b exp 0", bus.out_valid); else n_pass++;
      n_checks++; if (bus.reg_write !== 1'b0) $display("FAIL flush_reg_write: got %b exp 0", bus.reg_write); else n_pass++;
      exp_q.push_back(pk(4'b0100, 13, 1, 32'h40, 32'h50));
      @(negedge clk); bus.in_valid = 0; #1;
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL flush_resume: got %b exp 1", bus.out_valid); else n_pass++;
      n_checks++; if (bus.rd_addr !== 5'd13) $display("FAIL flush_resume_rd: got %0d exp 13", bus.rd_addr); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int acc;
      int cyc;
      logic [DW-1:0] r1, r2, imm;
      logic ui, rw;
      logic [3:0] op;
      logic [AW-1:0] rd;
      for (int phase = 0; phase < 2; phase++) begin
         acc = 0; cyc = 0;
         while (acc < 16 && cyc < 400) begin
            @(negedge clk);
            r1 = $urandom; r2 = $urandom; imm = $urandom;
            ui = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1));
            op = 4'($urandom_range(0, 6)); rd = AW'($urandom_range(0, 31));
            drive_instr(r1, r2, imm, AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)), rd, ui, op, rw);
            if (phase == 1) begin
               bus.in_valid  = 1'($urandom_range(0, 1));
               bus.out_ready = 1'($urandom_range(0, 1));
            end else begin
               bus.out_ready = 1;
            end
            #1;
            if (bus.in_valid && bus.in_ready) begin
               exp_q.push_back(pk(op, rd, rw, r1, ui ? imm : r2));
               acc++;
            end
            cyc++;
         end
         if (phase == 0) begin
            n_checks++; if (cyc != 16) $display("FAIL b2b_throughput: got %0d cycles exp 16", cyc); else n_pass++;
         end else begin
            n_checks++; if (acc != 16) $display("FAIL b2b_random_accepts: got %0d exp 16", acc); else n_pass++;
         end
      end
      @(negedge clk); bus.in_valid = 0; bus.out_ready = 1;
      repeat (3) @(negedge clk);
      #3;
      n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_drain: got %0d left exp 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_reset_and_saturate();
      @(negedge clk);
      drive_instr(32'h21, 32'h22, 0, 1, 2, 14, 0, 4'b0000, 1); bus.out_ready = 1; #1;
      exp_q.push_back(pk(4'b0000, 14, 1, 32'h21, 32'h22));
      @(negedge clk); bus.in_valid = 0; bus.out_ready = 0;
      repeat (2) @(negedge clk);
      #1; rst_n = 0; #1;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL async_rst_valid: got %b exp 0", bus.out_valid); else n_pass++;
      n_checks++; if (bus.stall_cycles !== 16'h0) $display("FAIL async_rst_stall: got %h exp 0000", bus.stall_cycles); else n_pass++;
      exp_q.delete();
      @(negedge clk); rst_n = 1;
      @(negedge clk);
      drive_instr(32'h61, 32'h62, 0, 1, 2, 15, 0, 4'b0011, 0); bus.out_ready = 1; #1;
      exp_q.push_back(pk(4'b0011, 15, 0, 32'h61, 32'h62));
      @(negedge clk); bus.in_valid = 0; bus.out_ready = 0;
      repeat (70000) @(negedge clk);
      #1;
      n_checks++; if (bus.stall_cycles !== 16'hFFFF) $display("FAIL stall_saturate: got %h exp FFFF", bus.stall_cycles); else n_pass++;
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL stall_held_valid: got %b exp 1", bus.out_valid); else n_pass++;
      @(negedge clk); bus.out_ready = 1;
      @(negedge clk); #3;
      n_checks++; if (bus.stall_cycles !== 16'hFFFF) $display("FAIL stall_sticky: got %h exp FFFF", bus.stall_cycles); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL final_drain: got %0d left exp 0", exp_q.size()); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_forward();
      test_hold_refresh();
      test_imm();
      test_flush();
      test_back_to_back();
      test_reset_and_saturate();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
